// File: rtl/sync_pkg.sv
// Shared constants and types for the button input conditioner.
// Defaults match the calculator's 8-line keypad bus.
package sync_pkg;

  localparam int BTN_WIDTH       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 4;

  typedef logic [BTN_WIDTH-1:0] btn_vec_t;

endpackage

// File: rtl/sync_chain.sv
// Per-bit multi-flop synchronizer chain for asynchronous inputs.
// Pure flops, no combinational logic between stages.
module sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/synchronization.sv
// Button bus conditioner: synchronize, debounce the whole vector,
// and pulse Push once per newly accepted non-zero pattern.
module synchronization
  import sync_pkg::*;
#(
  parameter int WIDTH           = BTN_WIDTH,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] Button,
  output logic             Push
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] stable_q;
  logic [CW-1:0]    cnt_q;
  logic             push_q;

  logic differs;
  logic counting;
  logic is_new;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (Button),
    .q       (sync_q)
  );

  assign differs  = sync_q != cand_q;
  assign counting = cnt_q < CNT_MAX;
  assign is_new   = cand_q != stable_q;

  // Any change restarts qualification; a release updates stable silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      push_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (differs) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else if (counting) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (is_new) begin
        stable_q <= cand_q;
        push_q   <= |cand_q;
      end
    end
  end

  assign Push = push_q;

endmodule

// File: tb/tb_synchronization.sv
// Scoreboard bench: window-based reference model predicts pulse cycles,
// a negedge monitor matches every Push against the expected queue.
module tb_synchronization;

  localparam int S = 2;
  localparam int D = 4;

  logic       clock;
  logic       reset_n;
  logic [7:0] Button;
  logic       Push;

  int n_chk;
  int n_fail;
  int cyc;
  int pulse_cnt;
  int last_pulse;

  int         exp_q[$];
  logic [7:0] hist[$];
  logic [7:0] stable_m;

  synchronization dut (
    .clock   (clock),
    .reset_n (reset_n),
    .Button  (Button),
    .Push    (Push)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] sync_at(int k);
    if (k - S >= 1) return hist[k-S-1];
    return 8'h00;
  endfunction

  // A pattern is accepted once the synchronized value has been identical
  // on D+1 consecutive edges and differs from the last accepted pattern.
  task automatic model_edge(input logic [7:0] v);
    int n;
    logic [7:0] val;
    bit ok;
    hist.push_back(v);
    n = hist.size();
    val = sync_at(n);
    ok = 1'b1;
    for (int k = n - D; k <= n; k++) begin
      if (sync_at(k) != val) ok = 1'b0;
    end
    if (ok && val != stable_m) begin
      stable_m = val;
      if (val != 8'h00) exp_q.push_back(cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    stable_m = 8'h00;
  endtask

  task automatic edge_only();
    @(posedge clock);
    cyc++;
    if (reset_n) model_edge(Button);
  endtask

  task automatic step(input logic [7:0] v);
    Button = v;
    edge_only();
    @(negedge clock);
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    #1;
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      n_chk++;
      if (Push) begin
        n_fail++;
        $display("FAIL push_in_reset: got 1 expected 0 at cycle %0d", cyc);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_push: got none expected pulse at cycle %0d",
                 exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (Push) begin
        n_chk++;
        pulse_cnt++;
        last_pulse = cyc;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
        end else begin
          n_fail++;
          $display("FAIL unexpected_push: got pulse at cycle %0d expected none",
                   cyc);
        end
      end
    end
  end

  initial begin
    int p0;
    int c0;
    bit found;
    logic [7:0] cur;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    pulse_cnt = 0;
    last_pulse = -1;
    reset_n = 1'b0;
    Button = 8'h88;
    model_reset();

    // Test 1: reset with pattern held, then one pulse 6 edges later
    @(negedge clock);
    hold(8'h88, 3);
    reset_n = 1'b1;
    p0 = pulse_cnt;
    c0 = cyc + 1;
    hold(8'h88, 10);
    chk("t1_count", pulse_cnt - p0, 1);
    chk("t1_latency", last_pulse - c0, 6);

    // Test 2: A then B, one pulse each, no release between
    hold(8'h00, 10);
    p0 = pulse_cnt;
    c0 = cyc + 1;
    hold(8'b10001000, 10);
    chk("t2_latency_a", last_pulse - c0, 6);
    c0 = cyc + 1;
    hold(8'b01001000, 20);
    chk("t2_count", pulse_cnt - p0, 2);
    chk("t2_latency_b", last_pulse - c0, 6);

    // Test 3: four distinct patterns, 10 cycles each
    p0 = pulse_cnt;
    hold(8'h28, 10);
    c0 = last_pulse;
    hold(8'h18, 10);
    chk("t3_spacing", last_pulse - c0, 10);
    hold(8'h84, 10);
    hold(8'h44, 10);
    chk("t3_count", pulse_cnt - p0, 4);

    // Test 4: press, release, re-press the same pattern
    p0 = pulse_cnt;
    hold(8'h88, 10);
    chk("t4_first", pulse_cnt - p0, 1);
    hold(8'h00, 10);
    chk("t4_release", pulse_cnt - p0, 1);
    hold(8'h88, 10);
    chk("t4_repress", pulse_cnt - p0, 2);
    hold(8'h88, 10);
    chk("t4_held", pulse_cnt - p0, 2);

    // Test 5: short glitch over a released bus
    hold(8'h00, 10);
    p0 = pulse_cnt;
    hold(8'h10, 2);
    hold(8'h00, 12);
    chk("t5_glitch", pulse_cnt - p0, 0);
    hold(8'h10, 3);
    hold(8'h00, 12);
    chk("t5_glitch3", pulse_cnt - p0, 0);

    // Test 6: asynchronous reset while Push is high
    found = 1'b0;
    Button = 8'h81;
    for (int i = 0; i < 20 && !found; i++) begin
      edge_only();
      #2;
      if (Push) found = 1'b1;
      else @(negedge clock);
    end
    chk("t6_push_seen", int'(found), 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (Push !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_async_clear: got %b expected 0", Push);
    end
    @(negedge clock);
    hold(8'h81, 2);
    reset_n = 1'b1;
    p0 = pulse_cnt;
    hold(8'h81, 10);
    chk("t6_requalify", pulse_cnt - p0, 1);

    // Randomized segments checked by the scoreboard
    cur = 8'h81;
    for (int seg = 0; seg < 150; seg++) begin
      case ($urandom_range(0, 3))
        0: cur = 8'h00;
        1: cur = cur;
        default: cur = 8'($urandom_range(1, 255));
      endcase
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        model_reset();
        hold(cur, $urandom_range(1, 3));
        reset_n = 1'b1;
      end
      hold(cur, $urandom_range(1, 9));
    end
    hold(cur, 12);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
